// File: rtl/spi_shared_master_if.sv
// Bus bundle for spi_shared_master: client request/response handshake plus
// the shared SPI pins. The master modport is the arbiter/shifter side, the
// slave modport is the client/peripheral side.
interface spi_shared_master_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int CH_W   = 1
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH*LEN_W-1:0]  req_len;
  logic                     rsp_valid;
  logic [CH_W-1:0]          rsp_ch;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     busy;
  logic                     sclk;
  logic                     mosi;
  logic                     miso;
  logic [NUM_CH-1:0]        ss_n;

  modport master (
    input  req_valid, req_wdata, req_len, miso,
    output req_ready, rsp_valid, rsp_ch, rsp_rdata, busy, sclk, mosi, ss_n
  );

  modport slave (
    output req_valid, req_wdata, req_len, miso,
    input  req_ready, rsp_valid, rsp_ch, rsp_rdata, busy, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_shared_master.sv
// Shared-bus SPI master (mode 0, MSB first). Round-robin arbitration between
// NUM_CH clients, one chip select per client, per-request transfer length.
module spi_shared_master #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 4,
  parameter int CLK_DIV = 4,
  parameter int CH_W    = 1
) (
  input  logic                clk,
  input  logic                rst,
  spi_shared_master_if.master bus
);
  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] r_tx;       // left-aligned, current bit at MSB
  logic [DATA_W-1:0] r_rx;
  logic [LEN_W-1:0]  r_bit;      // bits still to send after the current one
  logic              r_last;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [CH_W-1:0]   r_rsp_ch;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [NUM_CH-1:0] r_ss_n;

  logic              w_found;
  logic [CH_W-1:0]   w_grant;
  logic [DATA_W-1:0] w_wdata;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_top;
  logic [DATA_W-1:0] w_tx_al;
  logic [DATA_W-1:0] w_tx_next;
  logic [DATA_W-1:0] w_rx_next;
  logic              w_cnt_done;

  // Round-robin search: first requester at or after r_ptr, wrapping around.
  always_comb begin
    // NOTE: defaults before the loop keep this purely combinational (no latch).
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NUM_CH]) begin
        w_found = 1'b1;
        w_grant = CH_W'((int'(r_ptr) + k) % NUM_CH);
      end
    end
  end

  assign w_wdata    = bus.req_wdata[int'(w_grant)*DATA_W +: DATA_W];
  assign w_len      = bus.req_len[int'(w_grant)*LEN_W +: LEN_W];
  assign w_top      = (w_len > LEN_MAX) ? LEN_MAX : w_len;
  assign w_tx_al    = w_wdata << (LEN_MAX - w_top);
  assign w_tx_next  = r_tx << 1;
  assign w_rx_next  = (r_rx << 1) | DATA_W'(bus.miso);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // The accept pulse is a decode of the IDLE state and the arbiter so the
  // client sees ready in the same cycle its data is sampled; held off in reset.
  assign bus.req_ready = (r_state == S_IDLE && w_found && !rst)
                         ? (NUM_CH'(1) << w_grant) : '0;

  assign bus.sclk      = r_sclk;
  assign bus.mosi      = r_mosi;
  assign bus.ss_n      = r_ss_n;
  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_ch    = r_rsp_ch;
  assign bus.rsp_rdata = r_rsp_rdata;

  // Transfer sequencer: arbitration, SCLK generation, shifting and response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bit       <= '0;
      r_last      <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_ch    <= '0;
      r_rsp_rdata <= '0;
      r_ss_n      <= '1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_SETUP;
            r_cnt   <= '0;
            r_ch    <= w_grant;
            r_ptr   <= (int'(w_grant) == NUM_CH - 1) ? '0 : w_grant + CH_W'(1);
            r_tx    <= w_tx_al;
            r_rx    <= '0;
            r_bit   <= w_top;
            r_last  <= 1'b0;
            r_mosi  <= w_tx_al[DATA_W-1];
            r_ss_n  <= ~(NUM_CH'(1) << w_grant);
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_cnt_done) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_rx    <= w_rx_next;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (w_cnt_done) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
            r_tx    <= w_tx_next;
            r_last  <= (r_bit == '0);
            r_mosi  <= (r_bit == '0) ? 1'b0 : w_tx_next[DATA_W-1];
            if (r_bit != '0) r_bit <= r_bit - LEN_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOW: begin
          if (w_cnt_done) begin
            r_cnt <= '0;
            if (r_last) begin
              r_state     <= S_GAP;
              r_ss_n      <= '1;
              r_rsp_valid <= 1'b1;
              r_rsp_ch    <= r_ch;
              r_rsp_rdata <= r_rx;
            end else begin
              r_state <= S_HIGH;
              r_sclk  <= 1'b1;
              r_rx    <= w_rx_next;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (w_cnt_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_shared_master.sv
// Bench for spi_shared_master: a 3-channel 16-bit instance driven from a
// vector table with a response scoreboard and a shared-bus slave model, plus
// a 1-channel 12-bit instance for the length clamp.
module tb_spi_shared_master;
  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int LW  = 4;
  localparam int CD  = 2;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_shared_master_if #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .CH_W(CW)) bus ();
  spi_shared_master #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .CLK_DIV(CD), .CH_W(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  spi_shared_master_if #(.NUM_CH(1), .DATA_W(12), .LEN_W(4), .CH_W(1)) bus2 ();
  spi_shared_master #(.NUM_CH(1), .DATA_W(12), .LEN_W(4), .CLK_DIV(2), .CH_W(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int          ch;
    logic [15:0] wdata;
    logic [3:0]  len;
    logic [15:0] resp;
    int          nbits;
    logic [15:0] exp_mosi;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          ch;
    int          nbits;
    logic [15:0] mosi;
    logic [15:0] rdata;
  } exp_t;

  vec_t vec[6];
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Client side: a channel requests while it has unaccepted issues.
  int              issued[NCH];
  int              acc_cnt[NCH];
  logic [NCH-1:0]  force_v = '0;
  logic [NCH-1:0]  acc_seen = '0;
  logic [15:0]     cur_wdata[NCH];
  logic [15:0]     cur_resp[NCH];
  logic [3:0]      cur_len[NCH];
  int              cur_nbits[NCH];
  logic            miso_q = 1'b0;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      issued[c] = 0; acc_cnt[c] = 0; cur_wdata[c] = '0;
      cur_resp[c] = '0; cur_len[c] = '0; cur_nbits[c] = 1;
    end
  end

  always_comb begin
    bus.req_valid = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.req_valid[c]        = (issued[c] > acc_cnt[c]) || force_v[c];
      bus.req_wdata[c*16 +: 16] = cur_wdata[c];
      bus.req_len[c*4 +: 4]     = cur_len[c];
    end
  end
  assign bus.miso = miso_q;

  // Accepts seen mid-cycle retire the request right after the accepting edge.
  always @(posedge clk)
    for (int c = 0; c < NCH; c++)
      if (acc_seen[c]) acc_cnt[c] <= acc_cnt[c] + 1;

  // Slave model, protocol monitor and scoreboard, all sampled mid-cycle.
  int          cyc = 0, acc_cyc = 0, slv_bits = 0, slv_nbits = 1, ssn_low = 0;
  int          viol = 0, rsp_cnt = 0, rdy1_cnt = 0;
  logic [15:0] slv_resp = '0, slv_mosi = '0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    acc_seen = bus.req_valid & bus.req_ready;
    for (int c = 0; c < NCH; c++)
      if (acc_seen[c]) begin
        acc_cyc = cyc; slv_resp = cur_resp[c]; slv_nbits = cur_nbits[c];
        slv_bits = 0; slv_mosi = '0; ssn_low = 0;
      end
    if (bus.req_ready[1]) rdy1_cnt++;
    if (bus.sclk && !prev_sclk) begin
      slv_mosi = (slv_mosi << 1) | 16'(bus.mosi);
      slv_bits++;
    end
    if (bus.sclk && prev_sclk && bus.mosi !== prev_mosi) viol++;
    if ($countones(~bus.ss_n) > 1 || $countones(bus.req_ready) > 1) viol++;
    if (bus.ss_n != '1 && !bus.busy) viol++;
    if (bus.ss_n != '1) ssn_low++;
    if (bus.rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("rsp_ch", 32'(bus.rsp_ch), e.ch);
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
        check("mosi_word", 32'(slv_mosi), 32'(e.mosi));
        check("sclk_rises", slv_bits, e.nbits);
        check("rsp_latency", cyc - acc_cyc, 1 + CD*(1 + 2*e.nbits));
        check("ssn_low_cycles", ssn_low, CD*(1 + 2*e.nbits));
      end
    end
    if (!bus.sclk)
      miso_q = (slv_bits < slv_nbits && bus.ss_n != '1) ? slv_resp[slv_nbits-1-slv_bits] : 1'b0;
    prev_sclk = bus.sclk;
    prev_mosi = bus.mosi;
  end

  task automatic issue(input int i);
    int c = vec[i].ch;
    cur_wdata[c] = vec[i].wdata;
    cur_len[c]   = vec[i].len;
    cur_resp[c]  = vec[i].resp;
    cur_nbits[c] = vec[i].nbits;
    issued[c]++;
  endtask

  task automatic expect_vec(input int i);
    sb.push_back('{vec[i].ch, vec[i].nbits, vec[i].exp_mosi, vec[i].exp_rdata});
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int c = 0; c < NCH; c++) if (issued[c] > acc_cnt[c]) pending = 1'b1;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((sb.size() != 0 || bus.busy || pending()) && n < 2000);
    check(name, 32'(n >= 2000), 0);
  endtask

  task automatic wait_acc(input int ch, input int target);
    int n = 0;
    while (acc_cnt[ch] < target && n < 500) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(n >= 500), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base, rsp_b, rdy_b, n, bits;
    logic [11:0] mosi2;
    logic p2;

    //          ch  wdata     len   resp      nbits mosi      rdata
    vec[0] = '{0, 16'h00A5, 4'd7,  16'h003C, 8,  16'h00A5, 16'h003C};
    vec[1] = '{0, 16'h0001, 4'd0,  16'h0001, 1,  16'h0001, 16'h0001};
    vec[2] = '{1, 16'hFFFE, 4'd0,  16'hFFFE, 1,  16'h0000, 16'h0000};
    vec[3] = '{2, 16'hBEEF, 4'd15, 16'h1234, 16, 16'hBEEF, 16'h1234};
    vec[4] = '{1, 16'hFFF6, 4'd3,  16'h800F, 4,  16'h0006, 16'h000F};
    vec[5] = '{1, 16'h0C3A, 4'd11, 16'h5A5A, 12, 16'h0C3A, 16'h0A5A};

    rst = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_wdata = '0; bus2.req_len = '0; bus2.miso = 1'b0;
    force_v = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n", 32'(bus.ss_n), 32'h7);
    check("rst_sclk", 32'(bus.sclk), 0);
    check("rst_mosi", 32'(bus.mosi), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_ch", 32'(bus.rsp_ch), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    @(posedge clk); #1 force_v = '0; rst = 1'b0;

    // Vector table, one transfer at a time.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      expect_vec(i);
      issue(i);
      wait_drain($sformatf("drain_vec%0d", i));
    end

    // Contention after reset: ch0 before ch1, then ch0 wins again over ch1.
    do_reset();
    @(posedge clk); #1;
    expect_vec(0); expect_vec(4);
    issue(0); issue(4);
    wait_acc(1, acc_cnt[1] + 1);
    @(posedge clk); #1;
    expect_vec(1); expect_vec(5);
    issue(1); issue(5);
    wait_drain("drain_contention");

    // Round robin: all three channels held valid for two transfers each.
    do_reset();
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin expect_vec(1); expect_vec(2); expect_vec(3); end
    issue(1); issue(1); issue(2); issue(2); issue(3); issue(3);
    wait_drain("drain_rr");

    // Withdrawal: ch1 requests during a ch2 transfer and drops before grant.
    base  = acc_cnt[1];
    rdy_b = rdy1_cnt;
    @(posedge clk); #1;
    expect_vec(3); issue(3);
    repeat (6) @(posedge clk);
    #1 force_v[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1 force_v[1] = 1'b0;
    wait_drain("drain_withdraw");
    check("withdraw_no_accept", acc_cnt[1] - base, 0);
    check("withdraw_no_ready", rdy1_cnt - rdy_b, 0);

    // Reset at bit 3 of a ch1 transfer.
    base = acc_cnt[1];
    @(posedge clk); #1;
    issue(5);
    wait_acc(1, base + 1);
    n = 0;
    while (slv_bits < 4 && n < 500) begin @(negedge clk); n++; end
    check("reset_wait_bit3", 32'(n >= 500), 0);
    rsp_b = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ss_n", 32'(bus.ss_n), 32'h7);
    check("midrst_sclk", 32'(bus.sclk), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", rsp_cnt - rsp_b, 0);
    check("midrst_no_reaccept", acc_cnt[1] - base, 1);
    @(posedge clk); #1;
    expect_vec(4); issue(4);
    wait_drain("drain_after_reset");

    // Clamp on the 12-bit instance: len=15 must send exactly 12 bits.
    bus2.req_wdata = 12'hABC;
    bus2.req_len   = 4'hF;
    bus2.miso      = 1'b1;
    @(posedge clk); #1 bus2.req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.req_ready[0] && n < 20);
    check("clamp_accept", 32'(bus2.req_ready[0]), 1);
    @(posedge clk); #1 bus2.req_valid = 1'b0;
    n = 0; bits = 0; mosi2 = '0; p2 = 1'b0;
    do begin
      @(negedge clk); n++;
      if (bus2.sclk && !p2) begin mosi2 = {mosi2[10:0], bus2.mosi}; bits++; end
      p2 = bus2.sclk;
    end while (!bus2.rsp_valid && n < 200);
    check("clamp_bits", bits, 12);
    check("clamp_mosi", 32'(mosi2), 32'hABC);
    check("clamp_rdata", 32'(bus2.rsp_rdata), 32'hFFF);
    check("clamp_latency", n, 51);

    check("protocol_violations", viol, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_shared_master.md
# spi_shared_master

Parametrised SPI master that serves NUM_CH independent client channels over one shared SCLK/MOSI/MISO bus, each with its own active-low chip select. It replaces the per-device SPI masters and external SCLK mux at the top level: clients such as the flash reader and the lux sensor reader each raise a request, and a round-robin arbiter serialises their transfers. Transfer length is selectable per request. SPI mode 0 only, MSB first.

## Interface
Parameters:
- NUM_CH, 2: number of client channels/slaves (>=1)
- DATA_W, 16: maximum bits per transfer (>=1)
- LEN_W, 4: width of per-channel length field; must satisfy 2^LEN_W >= DATA_W
- CLK_DIV, 4: SCLK half-period in clk cycles (>=1)
- CH_W, 1: width of channel index; equals max(1, $clog2(NUM_CH))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- req_valid  in  NUM_CH  per-channel transfer request, held until accepted
- req_ready  out  NUM_CH  one-cycle accept pulse, at most one bit set
- req_wdata  in  NUM_CH*DATA_W  per-channel TX word; channel i at [i*DATA_W +: DATA_W]
- req_len  in  NUM_CH*LEN_W  per-channel bit count minus one
- rsp_valid  out  1  one-cycle completion pulse
- rsp_ch  out  CH_W  channel index of the completed transfer, valid with rsp_valid
- rsp_rdata  out  DATA_W  received bits, right-aligned, zero-extended; held until next completion
- busy  out  1  high from accept through the end of the inter-transfer gap
- sclk  out  1  shared serial clock, idles low
- mosi  out  1  shared serial data out
- miso  in  1  shared serial data in
- ss_n  out  NUM_CH  per-channel chip select, active low, at most one low

## Operation
- States: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE: if any req_valid, grant the first requesting channel at or after ptr, in round-robin order. Assert req_ready[g] for that cycle and latch wdata, len, and g. Set ptr = g+1 mod NUM_CH. Go to SETUP.
- Length clamp: nbits = min(req_len, DATA_W-1) + 1.
- SETUP (CLK_DIV cycles): ss_n[g]=0, sclk=0, mosi = wdata[nbits-1]. Then go to HIGH.
- HIGH (CLK_DIV cycles): sclk=1. miso is captured into the shift register on the clk edge that drives sclk high. Then go to LOW.
- LOW (CLK_DIV cycles): sclk=0. On entry, mosi advances to the next lower bit, or drives 0 after the last bit. Go to HIGH if bits remain. After the last bit's LOW, deassert ss_n, pulse rsp_valid, update rsp_ch/rsp_rdata, and go to GAP.
- GAP (CLK_DIV cycles): all ss_n high, no grant. Then go to IDLE, with busy low on entry to IDLE.
- Arbitration:
  - A request not granted stays pending.
  - Dropping req_valid before acceptance withdraws the request, with no side effects.
  - req_wdata/req_len are sampled only in the accept cycle.
  - With simultaneous requests, the grant goes to the lowest index >= ptr, wrapping around.
- Reset:
  - Outputs: sclk=0, mosi=0, ss_n=all 1, req_ready=0, rsp_valid=0, rsp_ch=0, rsp_rdata=0, busy=0.
  - Internal: ptr=0, state IDLE.
  - Reset mid-transfer aborts the transfer on the next edge: ss_n high, no rsp_valid, the pending client is not acknowledged again.

## Timing
- Accept at cycle A. Then ss_n[g] falls at A+1 and busy rises at A+1.
- First sclk rise at A+1+CLK_DIV. Bit k (0 = first) rises at A+1+CLK_DIV+2k*CLK_DIV.
- ss_n low for CLK_DIV*(1+2*nbits) cycles. rsp_valid is high in the cycle ss_n returns high, at A+1+CLK_DIV*(1+2*nbits).
- Earliest next accept is CLK_DIV cycles after rsp_valid.
- Per transfer, mosi changes only while sclk is low or in SETUP. Slave setup/hold margin is CLK_DIV clk cycles.
- rsp_rdata: bit nbits-1 is the first miso sample and bit 0 the last; bits above nbits-1 are 0.

## Test plan
- Single transfer, CLK_DIV=2, ch0, len=7, wdata=0xA5, slave returns 0x3C:
  - MOSI bits are 10100101 on successive rising edges.
  - ss_n[0] is low for 34 cycles.
  - rsp_valid occurs 35 cycles after accept, with rsp_ch=0 and rsp_rdata=0x003C.
- Short and clamped lengths, DATA_W=16:
  - len=0 sends 1 bit and rsp_rdata is 0 or 1.
  - len=15 sends 16 bits; wdata=0xBEEF is seen on MOSI.
  - With DATA_W=12 and len=15, the transfer is clamped to 12 bits.
- Contention: ch0 and ch1 request in the same cycle after reset.
  - ch0 is granted first, then ch1 after ch0's GAP.
  - Re-raising ch0 during ch1's transfer gives ch0 the next grant.
  - Never two ss_n low at once.
- Round-robin with NUM_CH=3: all channels held valid for 6 transfers -> grant order 0,1,2,0,1,2.
- Withdrawal: ch1 raises req_valid while ch0 is busy and drops it before the grant -> no ch1 transfer and no req_ready[1].
- Reset mid-transfer: assert rst at bit 3 of a ch1 transfer.
  - Next cycle: ss_n=all 1, sclk=0, busy=0, and no rsp_valid.
  - A later ch1 request is granted and completes normally.
